// File: rtl/mem_access.sv
// Memory-access stage: runs data-memory loads/stores via req/ack, forwards results to write-back.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op_mem,
  input  logic [4:0]        Ri_memi,
  input  logic [31:0]       alu_mem,
  input  logic [31:0]       B_mem,
  input  logic              ife_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [5:0]        op_wb,
  output logic [4:0]        Ri_wbi,
  output logic [31:0]       write_wb,
  output logic              ife_wb,
  output logic              mem_err
);

  localparam logic [5:0] OP_LOAD  = 6'b010001;
  localparam logic [5:0] OP_STORE = 6'b010000;
  localparam logic [5:0] OP_NONE  = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [5:0]  op_q;
  logic [4:0]  ri_q;
  logic [31:0] alu_q;
  logic [31:0] b_q;
  logic        ife_q;

  logic        is_mem;
  logic        accept;
  logic        done;
  logic        tmo;
  logic        tmo_hit;

  assign is_mem = (op_mem == OP_LOAD) ||
                  (op_mem == OP_STORE);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign tmo_hit = (cnt == CNT_LAST);
  assign mem_err = err_q;

  // err_q follows tmo, so it is high only in the WB cycle after a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
      if (accept) begin
        cnt <= '0;
      end else if (state == REQ && !mem_ack) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = is_mem ? REQ : WB;
        end
      end
      REQ: begin
        if (mem_ack) begin
          done     = 1'b1;
          state_nx = WB;
        end else if (tmo_hit) begin
          tmo      = 1'b1;
          state_nx = WB;
        end
      end
      WB: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      ri_q  <= '0;
      alu_q <= '0;
      b_q   <= '0;
      ife_q <= 1'b0;
    end else if (accept) begin
      op_q  <= op_mem;
      ri_q  <= Ri_memi;
      alu_q <= alu_mem;
      b_q   <= B_mem;
      ife_q <= ife_mem;
    end
  end

  // Write-back bundle changes only on the edge that enters WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wb    <= '0;
      Ri_wbi   <= '0;
      write_wb <= '0;
      ife_wb   <= 1'b0;
    end else if (accept && !is_mem) begin
      op_wb    <= op_mem;
      Ri_wbi   <= Ri_memi;
      write_wb <= alu_mem;
      ife_wb   <= ife_mem;
    end else if (done) begin
      op_wb    <= op_q;
      Ri_wbi   <= ri_q;
      write_wb <= (op_q == OP_LOAD) ? mem_rdata : alu_q;
      ife_wb   <= ife_q;
    end else if (tmo) begin
      op_wb    <= OP_NONE;
      Ri_wbi   <= ri_q;
      write_wb <= '0;
      ife_wb   <= ife_q;
    end
  end

  assign in_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign wb_valid  = (state == WB);
  assign mem_addr  = alu_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign mem_we    = (op_q == OP_STORE);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a write-back scoreboard.
// Timeout scenarios run when MEM_TIMEOUT_EN is defined.
module tb_mem_access;

  localparam logic [5:0] OP_LOAD  = 6'b010001;
  localparam logic [5:0] OP_STORE = 6'b010000;
  localparam int         TMO      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op_mem;
  logic [4:0]  Ri_memi;
  logic [31:0] alu_mem;
  logic [31:0] B_mem;
  logic        ife_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [5:0]  op_wb;
  logic [4:0]  Ri_wbi;
  logic [31:0] write_wb;
  logic        ife_wb;
  logic        mem_err;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  ri;
    logic [31:0] data;
    logic        ife;
    logic        err;
  } wb_t;

  wb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  mem_access #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_mem    (op_mem),
    .Ri_memi   (Ri_memi),
    .alu_mem   (alu_mem),
    .B_mem     (B_mem),
    .ife_mem   (ife_mem),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_valid  (wb_valid),
    .op_wb     (op_wb),
    .Ri_wbi    (Ri_wbi),
    .write_wb  (write_wb),
    .ife_wb    (ife_wb),
    .mem_err   (mem_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, " op_wb"},    {26'd0, op_wb},    {26'd0, e.op});
      chk({tag, " Ri_wbi"},   {27'd0, Ri_wbi},   {27'd0, e.ri});
      chk({tag, " write_wb"}, write_wb,          e.data);
      chk({tag, " ife_wb"},   {31'd0, ife_wb},   {31'd0, e.ife});
      chk({tag, " mem_err"},  {31'd0, mem_err},  {31'd0, e.err});
      chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, " req_in_wb"}, {31'd0, mem_req}, 32'd0);
    end
  endtask

  // ack_at: REQ cycle (1-based) in which ack is driven; 0 = never
  task automatic do_txn(input string tag,
                        input logic [5:0] op,
                        input logic [4:0] ri,
                        input logic [31:0] alu,
                        input logic [31:0] b,
                        input logic ife,
                        input int ack_at,
                        input logic [31:0] rdata);
    wb_t e;
    bit  is_mem;
    bit  got;
    int  lat;
    int  nreq;
    int  exp_req;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    e.op   = op;
    e.ri   = ri;
    e.ife  = ife;
    e.err  = 1'b0;
    e.data = (op == OP_LOAD) ? rdata : alu;
    exp_req = is_mem ? ack_at : 0;
    if (is_mem && (ack_at == 0 || ack_at > TMO)) begin
      e.op    = 6'b111111;
      e.data  = 32'd0;
      e.err   = 1'b1;
      exp_req = TMO;
    end
    sb_q.push_back(e);
    chk({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    op_mem   = op;
    Ri_memi  = ri;
    alu_mem  = alu;
    B_mem    = b;
    ife_mem  = ife;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_mem   = 6'b001111;
    Ri_memi  = 5'd31;
    alu_mem  = ~alu;
    B_mem    = ~b;
    ife_mem  = ~ife;
    lat  = 1;
    nreq = 0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (wb_valid) begin
        got = 1'b1;
      end else begin
        if (mem_req) begin
          nreq++;
          chk({tag, " mem_addr"}, mem_addr, alu);
          chk({tag, " mem_we"}, {31'd0, mem_we},
              {31'd0, op == OP_STORE});
          if (op == OP_STORE) begin
            chk({tag, " mem_wdata"}, mem_wdata, b);
          end
          if (nreq == ack_at) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
          end
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        lat++;
      end
    end
    chk({tag, " wb_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({tag, " req_cycles"}, nreq, exp_req);
      chk({tag, " latency"}, lat, is_mem ? exp_req + 1 : 1);
      pop_chk(tag);
    end
  endtask

  initial begin
    wb_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_mem    = '0;
    Ri_memi   = '0;
    alu_mem   = '0;
    B_mem     = '0;
    ife_mem   = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    #12;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst mem_req",  {31'd0, mem_req},  32'd0);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst write_wb", write_wb, 32'd0);
    chk("rst op_wb",    {26'd0, op_wb},    32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst mem_err",  {31'd0, mem_err},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_txn("alu", 6'b000010, 5'd5, 32'h0000_1234,
           32'h0, 1'b0, 0, 32'h0);
    tick();
    chk("alu hold write_wb", write_wb, 32'h0000_1234);
    chk("alu hold wb_valid", {31'd0, wb_valid}, 32'd0);

    do_txn("load", OP_LOAD, 5'd9, 32'h0000_0040,
           32'h1111_2222, 1'b0, 3, 32'hDEAD_BEEF);
    tick();

    do_txn("store", OP_STORE, 5'd3, 32'h0000_0080,
           32'h5555_AAAA, 1'b0, 1, 32'h0);
    tick();

    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack   = 1'b0;
    chk("idle_ack mem_req",  {31'd0, mem_req},  32'd0);
    chk("idle_ack wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("idle_ack in_ready", {31'd0, in_ready}, 32'd1);

    do_txn("branch", 6'b100000, 5'd0, 32'h0000_0100,
           32'h0, 1'b1, 0, 32'h0);
    // back-to-back request presented during WB must wait
    op_mem   = 6'b000011;
    Ri_memi  = 5'd7;
    alu_mem  = 32'h0000_0077;
    ife_mem  = 1'b0;
    in_valid = 1'b1;
    e.op = 6'b000011; e.ri = 5'd7; e.data = 32'h77;
    e.ife = 1'b0;     e.err = 1'b0;
    sb_q.push_back(e);
    tick();
    chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("b2b hold write_wb", write_wb, 32'h0000_0100);
    tick();
    in_valid = 1'b0;
    pop_chk("b2b");
    tick();

    do_txn("jump", 6'b100001, 5'd31, 32'hFFFF_FFFC,
           32'h0, 1'b0, 0, 32'h0);
    tick();

    // reset in the 2nd REQ cycle of a load
    op_mem   = OP_LOAD;
    Ri_memi  = 5'd4;
    alu_mem  = 32'h0000_00C0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rstreq req1", {31'd0, mem_req}, 32'd1);
    tick();
    chk("rstreq req2", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq mem_req",  {31'd0, mem_req},  32'd0);
    chk("rstreq wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstreq in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstreq mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("rstreq late_ack wb", {31'd0, wb_valid}, 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("rstreq late_ack wb2", {31'd0, wb_valid}, 32'd0);
    chk("rstreq late_ack req", {31'd0, mem_req}, 32'd0);
    chk("rstreq write_wb", write_wb, 32'd0);

    do_txn("load2", OP_LOAD, 5'd12, 32'h0000_1000,
           32'h0, 1'b1, 2, 32'h1357_9BDF);
    tick();

`ifdef MEM_TIMEOUT_EN
    do_txn("timeout", OP_LOAD, 5'd6, 32'h0000_0200,
           32'h0, 1'b0, 0, 32'h0);
    tick();
    chk("timeout err_clear", {31'd0, mem_err}, 32'd0);
    do_txn("ack_on_tmo", OP_STORE, 5'd8, 32'h0000_0300,
           32'hCAFE_F00D, 1'b0, TMO, 32'h0);
    tick();
`endif

    chk("sb drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the multi-cycle CPU. Sits directly upstream of the write-back stage and feeds it `op_wb`, `Ri_wbi`, `write_wb` and `ife_wb`.
- Accepts one instruction at a time from execute. Performs the data-memory load or store through a req/ack handshake. Presents a registered result to write-back for one cycle, flagged by `wb_valid`.
- Non-memory ops pass through with the ALU result as `write_wb`.

Parameters:
- `ADDR_W`, 32, width of `mem_addr`; `mem_addr = alu_mem[ADDR_W-1:0]`.
- `TIMEOUT_CYCLES`, 16, maximum REQ cycles without `mem_ack`. Used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  execute presents an instruction
- `in_ready`  out  1  stage can accept; high only in IDLE
- `op_mem`  in  6  opcode
- `Ri_memi`  in  5  destination register index
- `alu_mem`  in  32  ALU result / memory address / branch target
- `B_mem`  in  32  store data
- `ife_mem`  in  1  branch-condition flag
- `mem_req`  out  1  data-memory request
- `mem_we`  out  1  1 = store, 0 = load
- `mem_addr`  out  ADDR_W  data-memory address
- `mem_wdata`  out  32  store data
- `mem_rdata`  in  32  load data, valid when `mem_ack` = 1
- `mem_ack`  in  1  memory completes request
- `wb_valid`  out  1  one-cycle pulse: write-back outputs are valid
- `op_wb`  out  6  registered opcode to write-back
- `Ri_wbi`  out  5  registered destination index
- `write_wb`  out  32  registered result
- `ife_wb`  out  1  registered branch flag
- `mem_err`  out  1  one-cycle pulse on memory timeout

Behaviour:
- Opcodes:
  - `6'b010001` = load
  - `6'b010000` = store
  - all others = non-memory, including ALU `00xxxx`, branch `100000`, jump `100001` and undefined codes.
- FSM states: IDLE, REQ, WB. Reset state is IDLE.
- Reset values (async, immediate): all outputs 0, except `in_ready` = 1 (IDLE). This holds `mem_req`, `wb_valid`, `mem_err`, `op_wb`, `Ri_wbi`, `write_wb`, `ife_wb`, `mem_addr`, `mem_wdata` and `mem_we` at 0.
- IDLE:
  - `in_ready` = 1.
  - On a clock edge with `in_valid` = 1, latch `op_mem`, `Ri_memi`, `alu_mem`, `B_mem`, `ife_mem`.
  - Load or store → REQ. Other ops → WB with `write_wb = alu_mem`.
- REQ:
  - `mem_req` = 1, held until ack.
  - `mem_addr`, `mem_wdata`, `mem_we` are driven from the latched values and stay stable for the whole REQ.
  - On an edge with `mem_ack` = 1: a load captures `mem_rdata` into `write_wb`; a store sets `write_wb = alu` (address). Then → WB.
  - `mem_req` is deasserted in WB.
- WB: `wb_valid` = 1 for exactly one cycle → IDLE.
- `op_wb`, `Ri_wbi`, `ife_wb` update on the same edge that enters WB. All four write-back outputs hold their values until the next WB entry.
- Latency:
  - Non-memory op: `wb_valid` the cycle after acceptance.
  - Memory op: `mem_req` the cycle after acceptance; `wb_valid` the cycle after the ack edge. Minimum is 2 cycles when ack comes in the first REQ cycle.
- Throughput: one instruction per 2 cycles minimum; `in_ready` = 0 in REQ and WB.
- `mem_ack` in IDLE or WB is ignored.
- `in_valid` while `in_ready` = 0 is ignored; no buffering.
- Reset during REQ: `mem_req` drops immediately and the transaction is discarded; no `wb_valid`.

Optional Feature:
- Macro `MEM_TIMEOUT_EN`.
- With the macro:
  - A counter is cleared on REQ entry and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the stage drops `mem_req` and goes to WB with `op_wb = 6'b111111` (write-back updates neither register nor PC) and `write_wb = 0`.
  - `mem_err` pulses in the same cycle as `wb_valid`.
  - An ack on the timeout edge wins: normal completion.
- Without the macro: REQ waits indefinitely; `mem_err` is tied to 0.

Test Plan:
- ALU op: `op_mem=000010`, `alu_mem=32'h0000_1234`, `Ri_memi=5` → next cycle `wb_valid=1`, `write_wb=32'h1234`, `Ri_wbi=5`, `op_wb=000010`; `mem_req` never asserted.
- Load: `op=010001`, `alu=32'h40`; memory acks after 3 cycles with `rdata=32'hDEAD_BEEF` → `mem_req` held 3 cycles with `mem_addr=32'h40` and `mem_we=0`; `write_wb=32'hDEAD_BEEF` with `wb_valid` the next cycle.
- Store: `op=010000`, `alu=32'h80`, `B=32'h5555_AAAA`, immediate ack → `mem_we=1`, `mem_wdata=32'h5555_AAAA` during REQ; `wb_valid` 2 cycles after acceptance.
- Branch pass-through: `op=100000`, `ife_mem=1`, `alu=32'h100` → `ife_wb=1`, `write_wb=32'h100`. A back-to-back `in_valid` is accepted only when `in_ready` returns to 1.
- `rst` asserted in the 2nd REQ cycle of a load → `mem_req`=0 and `wb_valid`=0 immediately; `in_ready`=1; a later ack is ignored.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES=4`, no ack → after 4 REQ cycles `wb_valid=1`, `mem_err=1`, `op_wb=111111`, `write_wb=0`.
